// File: rtl/present_pkg.sv
// present_pkg: shared constants, types and PRESENT cipher primitives.
// Holds the S-box / inverse S-box lookups, pLayer / inverse pLayer,
// the decryptor FSM state enum, the LA command framing struct and the
// address / read-select encodings. No ports.
package present_pkg;

  localparam int ROUNDS = 31;
  localparam int KEY_W  = 80;
  localparam int BLK_W  = 64;

  // Write addresses
  localparam logic [2:0] ADDR_CT_LO  = 3'd0;
  localparam logic [2:0] ADDR_CT_HI  = 3'd1;
  localparam logic [2:0] ADDR_KEY_LO = 3'd2;
  localparam logic [2:0] ADDR_KEY_MD = 3'd3;
  localparam logic [2:0] ADDR_KEY_HI = 3'd4;

  // Readback selects
  localparam logic [1:0] RD_PT_LO  = 2'd0;
  localparam logic [1:0] RD_PT_HI  = 2'd1;
  localparam logic [1:0] RD_STATUS = 2'd2;
  localparam logic [1:0] RD_CT_LO  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_KEYEXP, S_ROUND, S_FINAL} state_e;

  // Field layout of the 39-bit LA command bus, MSB first.
  typedef struct packed {
    logic [1:0]  sel;
    logic        start;
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] data;
  } la_cmd_t;

  // Nibble tables, entry x at bits [4x+3:4x].
  localparam logic [63:0] SBOX_TBL  = 64'h2174_8FE3_DA09_B65C;
  localparam logic [63:0] ISBOX_TBL = 64'hA970_364B_D21C_8FE5;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX_TBL[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    return ISBOX_TBL[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [BLK_W-1:0] inv_sbox_layer(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] r;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = inv_sbox(s[4*i +: 4]);
    return r;
  endfunction

  // Bit i moves to (16*i) mod 63; bit 63 stays put.
  function automatic logic [BLK_W-1:0] player(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] r;
    for (int i = 0; i < 63; i++) r[(16*i) % 63] = s[i];
    r[63] = s[63];
    return r;
  endfunction

  function automatic logic [BLK_W-1:0] inv_player(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] r;
    for (int i = 0; i < 63; i++) r[i] = s[(16*i) % 63];
    r[63] = s[63];
    return r;
  endfunction

endpackage

// File: rtl/present_key_sched.sv
// present_key_sched: combinational PRESENT-80 key update, both directions.
//   key_i [79:0]  current key register
//   rc_i  [4:0]   round counter
//   inv_i         0 = forward update, 1 = inverse update
//   key_o [79:0]  updated key
module present_key_sched
  import present_pkg::*;
(
  input  logic [KEY_W-1:0] key_i,
  input  logic [4:0]       rc_i,
  input  logic             inv_i,
  output logic [KEY_W-1:0] key_o
);

  logic [KEY_W-1:0] fwd, bwd;

  always_comb begin
    // forward: rotate left 61, S-box top nibble, counter into [19:15]
    fwd         = {key_i[18:0], key_i[79:19]};
    fwd[79:76]  = sbox(fwd[79:76]);
    fwd[19:15]  = fwd[19:15] ^ rc_i;
    // inverse undoes those steps in reverse order; rotate right 61 == left 19
    bwd         = key_i;
    bwd[19:15]  = bwd[19:15] ^ rc_i;
    bwd[79:76]  = inv_sbox(bwd[79:76]);
    key_o       = inv_i ? {bwd[60:0], bwd[79:61]} : fwd;
  end

endmodule

// File: rtl/present_dec_la.sv
// present_dec_la: iterative PRESENT-80 decryptor driven over the LA bus.
//   wb_clk_i          system clock
//   wb_rst_ni         async active-low reset
//   la_data_in [38:0] {sel[1:0], start, wr, addr[2:0], data[31:0]}
//   la_data_out[31:0] registered readback (pt lo / pt hi / status / ct lo)
// Optional macro PRESENT_DEC_KEYCACHE_EN keeps K32 so repeat starts with an
// unchanged key skip key expansion.
module present_dec_la
  import present_pkg::*;
(
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic [38:0] la_data_in,
  output logic [31:0] la_data_out
);

  la_cmd_t          cmd_q;
  logic             wr_prev_q, st_prev_q;
  logic             wr_edge, st_edge, busy, cached;
  state_e           state_q, state_d;
  logic [4:0]       rc_q, rc_d;
  logic [BLK_W-1:0] ct_q, ct_d, blk_q, blk_d, pt_q, pt_d;
  logic [KEY_W-1:0] key_q, key_d, wk_q, wk_d, ks_out;
  logic             done_q, done_d;
  logic [31:0]      out_d, out_q;
`ifdef PRESENT_DEC_KEYCACHE_EN
  logic [KEY_W-1:0] kc_q, kc_d;
  logic             kc_vld_q, kc_vld_d;
  assign cached = kc_vld_q;
`else
  assign cached = 1'b0;
`endif

  assign wr_edge = cmd_q.wr    & ~wr_prev_q;
  assign st_edge = cmd_q.start & ~st_prev_q;
  assign busy    = (state_q != S_IDLE);

  // Inverse direction only while walking the rounds back down.
  present_key_sched u_ks (
    .key_i (wk_q),
    .rc_i  (rc_q),
    .inv_i (state_q == S_ROUND),
    .key_o (ks_out)
  );

  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    ct_d    = ct_q;
    key_d   = key_q;
    blk_d   = blk_q;
    wk_d    = wk_q;
    pt_d    = pt_q;
    done_d  = done_q;
`ifdef PRESENT_DEC_KEYCACHE_EN
    kc_d     = kc_q;
    kc_vld_d = kc_vld_q;
`endif
    // Write first so a same-cycle start sees the new words.
    if (!busy && wr_edge) begin
      done_d = 1'b0;
      case (cmd_q.addr)
        ADDR_CT_LO:  ct_d[31:0]   = cmd_q.data;
        ADDR_CT_HI:  ct_d[63:32]  = cmd_q.data;
        ADDR_KEY_LO: key_d[31:0]  = cmd_q.data;
        ADDR_KEY_MD: key_d[63:32] = cmd_q.data;
        ADDR_KEY_HI: key_d[79:64] = cmd_q.data[15:0];
        default: ;
      endcase
`ifdef PRESENT_DEC_KEYCACHE_EN
      if (cmd_q.addr inside {ADDR_KEY_LO, ADDR_KEY_MD, ADDR_KEY_HI}) kc_vld_d = 1'b0;
`endif
    end
    case (state_q)
      S_IDLE: if (st_edge) begin
        done_d = 1'b0;
        blk_d  = ct_d;
`ifdef PRESENT_DEC_KEYCACHE_EN
        if (kc_vld_d) begin
          wk_d    = kc_q;
          rc_d    = 5'(ROUNDS);
          state_d = S_ROUND;
        end else begin
          wk_d    = key_d;
          rc_d    = 5'd1;
          state_d = S_KEYEXP;
        end
`else
        wk_d    = key_d;
        rc_d    = 5'd1;
        state_d = S_KEYEXP;
`endif
      end
      S_KEYEXP: begin
        wk_d = ks_out;
        if (rc_q == 5'(ROUNDS)) begin
          state_d = S_ROUND;   // rc stays at 31 for the first inverse round
`ifdef PRESENT_DEC_KEYCACHE_EN
          kc_d     = ks_out;
          kc_vld_d = 1'b1;
`endif
        end else begin
          rc_d = rc_q + 5'd1;
        end
      end
      S_ROUND: begin
        blk_d = inv_sbox_layer(inv_player(blk_q ^ wk_q[79:16]));
        wk_d  = ks_out;
        if (rc_q == 5'd1) state_d = S_FINAL;
        else              rc_d    = rc_q - 5'd1;
      end
      S_FINAL: begin
        pt_d    = blk_q ^ wk_q[79:16];   // whitening with K1
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_d = '0;
    case (cmd_q.sel)
      RD_PT_LO:  out_d = pt_q[31:0];
      RD_PT_HI:  out_d = pt_q[63:32];
      RD_STATUS: out_d = {29'b0, cached, done_q, busy};
      RD_CT_LO:  out_d = ct_q[31:0];
      default:   out_d = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cmd_q     <= '0;
      wr_prev_q <= 1'b0;
      st_prev_q <= 1'b0;
      state_q   <= S_IDLE;
      rc_q      <= '0;
      ct_q      <= '0;
      key_q     <= '0;
      blk_q     <= '0;
      wk_q      <= '0;
      pt_q      <= '0;
      done_q    <= 1'b0;
      out_q     <= '0;
    end else begin
      cmd_q     <= la_cmd_t'(la_data_in);
      wr_prev_q <= cmd_q.wr;
      st_prev_q <= cmd_q.start;
      state_q   <= state_d;
      rc_q      <= rc_d;
      ct_q      <= ct_d;
      key_q     <= key_d;
      blk_q     <= blk_d;
      wk_q      <= wk_d;
      pt_q      <= pt_d;
      done_q    <= done_d;
      out_q     <= out_d;
    end
  end

`ifdef PRESENT_DEC_KEYCACHE_EN
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      kc_q     <= '0;
      kc_vld_q <= 1'b0;
    end else begin
      kc_q     <= kc_d;
      kc_vld_q <= kc_vld_d;
    end
  end
`endif

  assign la_data_out = out_q;

endmodule
